// File: rtl/counter_pkg.sv
// Shared definitions for the BCD counter family: pulse-train FSM states,
// the largest legal decimal digit and a packed-BCD validity check.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  // Widest packed BCD word the validity check understands.
  localparam int BCD_MAX_DIGITS = 8;

  // True when every nibble of the word is a legal decimal digit.
  // Narrower words are zero-extended by the caller; zero nibbles are legal.
  function automatic logic bcd_is_valid(input logic [4*BCD_MAX_DIGITS-1:0] word);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
      if (word[4*i +: 4] > BCD_MAX_DIGIT) begin
        ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One decimal digit of a down-counter: loadable, decrements when enabled,
// wraps 0 -> 9 and raises a combinational borrow for the next digit up.
module bcd_digit_down
  import counter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       en,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic       borrow_out
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = d;
    end else if (en) begin
      q_d = (q_q == 4'd0) ? BCD_MAX_DIGIT : q_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q          = q_q;
  assign borrow_out = en && (q_q == 4'd0);

endmodule

// File: rtl/bcd_pulse_emitter.sv
// Loads a packed BCD count on start and emits that many PW-wide pulses
// separated by GAP low cycles, then strobes done.
module bcd_pulse_emitter
  import counter_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int PW     = 1,
  parameter int GAP    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd,
  input  logic                  abort,
  output logic                  pulse,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [4*DIGITS-1:0]   remaining
);

  localparam int PHASE_MAX = (PW > GAP) ? PW : GAP;
  localparam int TW        = $clog2(PHASE_MAX) + 1;
  localparam logic [TW-1:0] PW_LAST  = TW'(PW - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP - 1);
  localparam logic [4*DIGITS-1:0] COUNT_ONE = (4*DIGITS)'(1);

  if (PW < 1) begin : g_bad_pw
    $error("bcd_pulse_emitter: PW must be at least 1");
  end
  if (GAP < 1) begin : g_bad_gap
    $error("bcd_pulse_emitter: GAP must be at least 1");
  end
  if (DIGITS < 1 || DIGITS > BCD_MAX_DIGITS) begin : g_bad_digits
    $error("bcd_pulse_emitter: DIGITS out of range");
  end

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            pulse_q, pulse_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            load;
  logic            dec;
  logic [DIGITS:0] borrow;
  logic            top_borrow_unused;
  logic [4*BCD_MAX_DIGITS-1:0] bcd_ext;

  assign bcd_ext = (4*BCD_MAX_DIGITS)'(bcd);

  // Borrow ripples upward; the top digit's borrow cannot fire on a nonzero count.
  assign borrow[0]         = dec;
  assign top_borrow_unused = borrow[DIGITS];

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    bcd_digit_down u_digit (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .en         (borrow[gi]),
      .d          (bcd[4*gi +: 4]),
      .q          (remaining[4*gi +: 4]),
      .borrow_out (borrow[gi+1])
    );
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pulse_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    load    = 1'b0;
    dec     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (!bcd_is_valid(bcd_ext)) begin
            err_d = 1'b1;
          end else if (bcd == '0) begin
            done_d = 1'b1;
          end else begin
            load    = 1'b1;
            state_d = HIGH;
            timer_d = '0;
            pulse_d = 1'b1;
          end
        end
      end
      HIGH: begin
        if (abort) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == PW_LAST) begin
          dec     = 1'b1;
          timer_d = '0;
          // A count of one is about to reach zero: this was the final pulse.
          if (remaining == COUNT_ONE) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = LOW;
          end
        end else begin
          timer_d = timer_q + 1'b1;
          pulse_d = 1'b1;
        end
      end
      LOW: begin
        if (abort) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == GAP_LAST) begin
          state_d = HIGH;
          timer_d = '0;
          pulse_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign pulse = pulse_q;
  assign busy  = (state_q != IDLE);
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: doc/bcd_pulse_emitter.md
# bcd_pulse_emitter

Converts a multi-digit BCD value back into a pulse train: on `start` it loads a packed BCD count and emits exactly that many fixed-width pulses on `pulse`, then signals `done`. It is the inverse of the team's decimal counters, which turn pulses into BCD counts. It sits downstream of a BCD count register or a host preset, and drives event-driven logic that expects discrete strobes: steppers, test stimulus, counter loop-back.

## Interface
- `DIGITS`, default 2: number of BCD digits; the count range is 0 to 10^DIGITS−1.
- `PW`, default 1: pulse high time in clock cycles; must be ≥1.
- `GAP`, default 1: low time between consecutive pulses in cycles; must be ≥1.
- `clk`  in  1: single clock; all logic acts on the rising edge.
- `rst_n`  in  1: synchronous, active-high reset. The name follows the team's counter port naming; the polarity is high.
- `start`  in  1: load `bcd` and begin the train. Sampled only in IDLE.
- `bcd`  in  4*DIGITS: packed BCD count. Digit 0 is in bits [3:0].
- `abort`  in  1: stop the train immediately; no `done`.
- `pulse`  out  1: the emitted pulse train, registered.
- `busy`  out  1: high while the FSM is not in IDLE.
- `done`  out  1: one-cycle strobe after the last pulse, or after a zero count.
- `err`  out  1: one-cycle strobe when `start` arrives with any digit >9.
- `remaining`  out  4*DIGITS: BCD count of pulses not yet completed.

## Operation
- Reset: all outputs are 0, FSM is IDLE, and `remaining` is 0. Reset overrides `start` and `abort` in the same cycle.
- FSM states are IDLE, HIGH and LOW. A phase timer counts cycles within HIGH and LOW.
- IDLE with `start`=1:
  - Any digit >9: `err`=1 next cycle; stay in IDLE; `remaining` is unchanged.
  - Value is all zero: `done`=1 next cycle; stay in IDLE; no pulse.
  - Otherwise: `remaining` ← `bcd`; enter HIGH.
- HIGH: `pulse`=1 for PW cycles. On the last HIGH cycle, `remaining` decrements by one in BCD.
  - If the new value is 0: go to IDLE with `done`=1 that cycle.
  - Else: enter LOW.
- LOW: `pulse`=0 for GAP cycles, then enter HIGH.
- BCD decrement ripples a borrow from digit 0 upward. A digit at 0 with a borrow-in becomes 9 and borrows onward; any other digit simply decrements. Example: 10→09, 100→099. The top digit can never underflow because the count is nonzero when decremented.
- `start` while `busy` is ignored; `bcd` is not resampled.
- `abort`, when not IDLE, moves to IDLE at the next edge: `pulse`=0, no `done`, `remaining` holds its value. `abort` in IDLE has no effect. `abort` has priority over `start` in the same cycle.

## Timing
- Cycle 0 is the edge at which `start` is sampled.
- Pulse k (0-based) is high during cycles 1+k·(PW+GAP) through k·(PW+GAP)+PW.
- For count R, `done`=1 in cycle (R−1)·(PW+GAP)+PW+1. In that cycle `busy`=0 and `pulse`=0.
- `busy`=1 from cycle 1 through the last HIGH cycle.
- The earliest next `start` is sampled in the `done` cycle, giving back-to-back trains with a 1-cycle gap.
- Zero-count `done` and `err` both occur in cycle 1, with `busy` staying 0.
- The phase timer width is $clog2(max(PW,GAP))+1. Parameter checks for PW≥1 and GAP≥1 are elaboration-time assertions.

## Structure
- Shared package `counter_pkg` holds:
  - the FSM state enum (IDLE, HIGH, LOW);
  - the constant `BCD_MAX_DIGIT` = 4'd9;
  - a function that validates a packed BCD word.
- One sub-module, `bcd_digit_down`: a single-digit decimal down-counter.
  - Ports: `clk`, `rst_n`, `load`, `en`, `d[3:0]`, `q[3:0]`, `borrow_out`.
  - Instantiated DIGITS times, with the `en` of digit i+1 driven by the borrow of digit i.

## Test plan
- DIGITS=2, PW=1, GAP=1, `bcd`=8'h03 with `start` at cycle 0 → `pulse` high in cycles 1, 3, 5; `done` in cycle 6; `remaining` steps 03→02→01→00.
- `bcd`=8'h10 → 10 pulses; `remaining` goes 10→09 with a digit-0 borrow after the first pulse; `done` in cycle 20.
- `bcd`=8'h00 → `done` in cycle 1, never `pulse`/`busy`. `bcd`=8'h1A → `err` in cycle 1, no `done`, `remaining` unchanged.
- PW=3, GAP=2, `bcd`=8'h02 → `pulse` high in cycles 1–3 and 6–8; `done` in cycle 9. A `start` with 8'h05 in cycle 4 is ignored.
- `bcd`=8'h99, `abort` in cycle 10 → `pulse`=0 and `busy`=0 from cycle 11, no `done`, `remaining`=8'h94.
- `rst_n`=1 in cycle 7 of an 8'h05 train → all outputs 0 from cycle 8. A `start` in the reset cycle is ignored.
